// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, extracts load data from the
// data SRAM, buffers read data across writeback stalls. MS_PERF_CNT_EN adds a load-retire counter.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 76,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic [9:0]                 es_to_ms_addr,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [9:0]                 ms_to_ws_addr,
    output logic [31:0]                ms_forward_data,
    output logic                       ms_valid_tohazard,
    output logic                       ms_gr_we_tohazard,
    output logic [4:0]                 ms_dest_tohazard,
    output logic [31:0]                ms_load_cnt
);

    logic                       r_ms_valid;
    logic                       r_first;
    logic                       r_rbuf_vld;
    logic [31:0]                r_rbuf;
    logic [ES_TO_MS_BUS_WD-1:0] r_bus;
    logic [9:0]                 r_addr;

    logic        w_ready_go;
    logic        w_accept;
    logic        w_leave;
    logic        w_ld_w;
    logic        w_ld_h;
    logic        w_ld_b;
    logic        w_ld_sign;
    logic [1:0]  w_whb_mux;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc;
    logic        w_is_load;
    logic [31:0] w_rdata_eff;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_half_ext;
    logic [31:0] w_byte_ext;
    logic [31:0] w_ld_val;
    logic [31:0] w_final_result;

    assign w_ready_go = 1'b1;
    assign ms_allowin = !r_ms_valid || (w_ready_go && ws_allowin);
    assign w_accept   = es_to_ms_valid && ms_allowin;
    assign w_leave    = r_ms_valid && w_ready_go && ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
            r_first    <= 1'b0;
            r_rbuf_vld <= 1'b0;
        end else begin
            if (ms_allowin)
                r_ms_valid <= es_to_ms_valid;
            r_first <= w_accept;
            // SRAM data is only valid in the first cycle; keep it if writeback stalls us
            if (w_leave)
                r_rbuf_vld <= 1'b0;
            else if (r_ms_valid && r_first && !ws_allowin)
                r_rbuf_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_bus  <= es_to_ms_bus;
            r_addr <= es_to_ms_addr;
        end
        if (r_ms_valid && r_first && !ws_allowin)
            r_rbuf <= data_sram_rdata;
    end

    assign w_ld_w       = r_bus[75];
    assign w_ld_h       = r_bus[74];
    assign w_ld_b       = r_bus[73];
    assign w_ld_sign    = r_bus[72];
    assign w_whb_mux    = r_bus[71:70];
    assign w_gr_we      = r_bus[69];
    assign w_dest       = r_bus[68:64];
    assign w_alu_result = r_bus[63:32];
    assign w_pc         = r_bus[31:0];
    assign w_is_load    = w_ld_w | w_ld_h | w_ld_b;

    assign w_rdata_eff = r_rbuf_vld ? r_rbuf : data_sram_rdata;
    assign w_half      = w_whb_mux[1] ? w_rdata_eff[31:16] : w_rdata_eff[15:0];

    always_comb begin
        w_byte = w_rdata_eff[7:0];
        case (w_whb_mux)
            2'd0: w_byte = w_rdata_eff[7:0];
            2'd1: w_byte = w_rdata_eff[15:8];
            2'd2: w_byte = w_rdata_eff[23:16];
            2'd3: w_byte = w_rdata_eff[31:24];
            default: w_byte = w_rdata_eff[7:0];
        endcase
    end

    assign w_half_ext = {{16{w_ld_sign & w_half[15]}}, w_half};
    assign w_byte_ext = {{24{w_ld_sign & w_byte[7]}}, w_byte};

    // word beats halfword beats byte when several load bits are set
    always_comb begin
        w_ld_val = w_byte_ext;
        if (w_ld_w)
            w_ld_val = w_rdata_eff;
        else if (w_ld_h)
            w_ld_val = w_half_ext;
    end

    assign w_final_result = w_is_load ? w_ld_val : w_alu_result;

    assign ms_to_ws_valid    = r_ms_valid;
    assign ms_to_ws_bus      = {w_gr_we, w_dest, w_final_result, w_pc};
    assign ms_to_ws_addr     = r_addr;
    assign ms_forward_data   = w_final_result;
    assign ms_valid_tohazard = r_ms_valid;
    assign ms_gr_we_tohazard = w_gr_we && r_ms_valid;
    assign ms_dest_tohazard  = w_dest;

`ifdef MS_PERF_CNT_EN
    logic [31:0] r_load_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_load_cnt <= 32'd0;
        else if (w_leave && w_is_load)
            r_load_cnt <= r_load_cnt + 32'd1;
    end

    assign ms_load_cnt = r_load_cnt;
`else
    assign ms_load_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: randomized and directed traffic against a
// behavioural load-extraction model; the monitor checks every cycle at negedge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic [9:0]  es_to_ms_addr;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [9:0]  ms_to_ws_addr;
    logic [31:0] ms_forward_data;
    logic        ms_valid_tohazard;
    logic        ms_gr_we_tohazard;
    logic [4:0]  ms_dest_tohazard;
    logic [31:0] ms_load_cnt;

    mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .ws_allowin       (ws_allowin),
        .ms_allowin       (ms_allowin),
        .es_to_ms_valid   (es_to_ms_valid),
        .es_to_ms_bus     (es_to_ms_bus),
        .es_to_ms_addr    (es_to_ms_addr),
        .data_sram_rdata  (data_sram_rdata),
        .ms_to_ws_valid   (ms_to_ws_valid),
        .ms_to_ws_bus     (ms_to_ws_bus),
        .ms_to_ws_addr    (ms_to_ws_addr),
        .ms_forward_data  (ms_forward_data),
        .ms_valid_tohazard(ms_valid_tohazard),
        .ms_gr_we_tohazard(ms_gr_we_tohazard),
        .ms_dest_tohazard (ms_dest_tohazard),
        .ms_load_cnt      (ms_load_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
        logic [9:0]  addr;
        logic        is_load;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          xfer_cnt = 0;
    logic [31:0] model_cnt = 32'd0;
    logic        use_fill = 1'b0;
    logic [31:0] fill_word = 32'd0;

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Load result from the architectural rules: shift/mask the word, then extend.
    function automatic logic [31:0] model(input logic [75:0] b, input logic [31:0] word);
        logic [31:0] v;
        int          sh;
        if (b[75]) return word;
        if (b[74]) begin
            v = b[71] ? (word >> 16) : (word % 32'h10000);
            if (b[72] && v >= 32'h8000) v = v + 32'hFFFF0000;
            return v;
        end
        if (b[73]) begin
            sh = 8 * int'(b[71:70]);
            v  = (word >> sh) % 32'h100;
            if (b[72] && v >= 32'h80) v = v + 32'hFFFFFF00;
            return v;
        end
        return b[63:32];
    endfunction

    function automatic logic [75:0] mk_bus(input logic [3:0] ld_wbhs, input logic [1:0] mux,
                                           input logic [4:0] dest, input logic [31:0] alu,
                                           input logic [31:0] pc);
        return {ld_wbhs[3], ld_wbhs[2], ld_wbhs[1], ld_wbhs[0], mux, 1'b1, dest, alu, pc};
    endfunction

    // Called at posedge+1: drive one cycle, track acceptance, supply SRAM data next cycle.
    task automatic step(input logic v, input logic [75:0] bus, input logic [9:0] addr,
                        input logic [31:0] word, input logic ws);
        logic acc;
        exp_t e;
        es_to_ms_valid = v;
        es_to_ms_bus   = bus;
        es_to_ms_addr  = addr;
        ws_allowin     = ws;
        @(negedge clk);
        acc = v && ms_allowin;
        @(posedge clk);
        #1;
        if (acc) begin
            e.gr_we   = bus[69];
            e.dest    = bus[68:64];
            e.result  = model(bus, word);
            e.pc      = bus[31:0];
            e.addr    = addr;
            e.is_load = bus[75] | bus[74] | bus[73];
            q.push_back(e);
            data_sram_rdata = word;
        end else begin
            data_sram_rdata = use_fill ? fill_word : $urandom;
        end
    endtask

    task automatic idle(input logic ws);
        step(1'b0, 76'd0, 10'd0, 32'd0, ws);
    endtask

    // Hold a stall for one cycle and check the forwarded result directly.
    task automatic peek(input string nm, input logic [31:0] exp);
        es_to_ms_valid = 1'b0;
        ws_allowin     = 1'b0;
        @(negedge clk);
        chk(nm, ms_forward_data, exp);
        chk({nm, "_vld"}, ms_to_ws_valid, 1);
        chk({nm, "_alw"}, ms_allowin, 0);
        @(posedge clk);
        #1;
        data_sram_rdata = use_fill ? fill_word : $urandom;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            automatic logic exp_v = (q.size() != 0);
            automatic exp_t e;
            chk("valid", ms_to_ws_valid, exp_v);
            chk("hz_valid", ms_valid_tohazard, exp_v);
            chk("allowin", ms_allowin, !exp_v || ws_allowin);
            chk("load_cnt", ms_load_cnt, model_cnt);
            if (exp_v) begin
                e = q[0];
                chk("bus", ms_to_ws_bus, {e.gr_we, e.dest, e.result, e.pc});
                chk("addr", ms_to_ws_addr, e.addr);
                chk("fwd", ms_forward_data, e.result);
                chk("hz_we", ms_gr_we_tohazard, e.gr_we);
                chk("hz_dest", ms_dest_tohazard, e.dest);
                if (ws_allowin) begin
                    e = q.pop_front();
                    xfer_cnt++;
`ifdef MS_PERF_CNT_EN
                    if (e.is_load) model_cnt = model_cnt + 32'd1;
`endif
                end
            end else begin
                chk("hz_we_idle", ms_gr_we_tohazard, 0);
            end
        end
    end

    initial begin
        int x0;
        logic [75:0] b;
        reset           = 1'b1;
        ws_allowin      = 1'b0;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        es_to_ms_addr   = '0;
        data_sram_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", ms_to_ws_valid, 0);
        chk("rst_cnt", ms_load_cnt, 0);
        @(posedge clk);
        #1;

        // lb signed, byte 2
        step(1'b1, mk_bus(4'b0011, 2'd2, 5'd3, 32'hAAAA0000, 32'h100), 10'h3A5, 32'h12F45678, 1'b0);
        peek("lb_sext", 32'hFFFFFFF4);
        idle(1'b1);
        // lhu, upper half
        step(1'b1, mk_bus(4'b0100, 2'd2, 5'd4, 32'hBBBB0000, 32'h104), 10'h011, 32'h8001ABCD, 1'b0);
        peek("lhu_zext", 32'h00008001);
        idle(1'b1);
        // lw stalled 3 cycles while SRAM data changes underneath
        use_fill  = 1'b1;
        fill_word = 32'hDEADBEEF;
        step(1'b1, mk_bus(4'b1000, 2'd0, 5'd5, 32'h0, 32'h108), 10'h2F0, 32'h11223344, 1'b0);
        repeat (3) peek("lw_hold", 32'h11223344);
        idle(1'b1);
        use_fill = 1'b0;
        // multiple load bits: word wins, then halfword
        step(1'b1, mk_bus(4'b1110, 2'd1, 5'd6, 32'h0, 32'h10C), 10'h0, 32'hCAFEF00D, 1'b1);
        step(1'b1, mk_bus(4'b0111, 2'd0, 5'd7, 32'h0, 32'h110), 10'h0, 32'h1234FF80, 1'b1);
        idle(1'b1);

        // five back-to-back ALU ops
        x0 = xfer_cnt;
        for (int i = 0; i < 5; i++)
            step(1'b1, mk_bus(4'b0000, 2'd0, 5'(i + 8), 32'h5000 + i, 32'h200 + 4 * i),
                 10'(i), $urandom, 1'b1);
        idle(1'b1);
        chk("b2b_count", xfer_cnt - x0, 5);

        // reset while a load is stalled
        step(1'b1, mk_bus(4'b1000, 2'd0, 5'd9, 32'h0, 32'h300), 10'h1, 32'h77777777, 1'b0);
        idle(1'b0);
        reset          = 1'b1;
        es_to_ms_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        model_cnt = 32'd0;
        @(negedge clk);
        chk("rst_stall_valid", ms_to_ws_valid, 0);
        chk("rst_stall_cnt", ms_load_cnt, 0);
        @(posedge clk);
        #1;

`ifdef MS_PERF_CNT_EN
        force dut.r_load_cnt = 32'hFFFFFFFF;
        model_cnt = 32'hFFFFFFFF;
        @(negedge clk);
        #1;
        release dut.r_load_cnt;
        @(posedge clk);
        #1;
        step(1'b1, mk_bus(4'b1000, 2'd0, 5'd1, 32'h0, 32'h400), 10'h0, 32'h1, 1'b1);
        idle(1'b1);
        @(negedge clk);
        chk("cnt_wrap", ms_load_cnt, 0);
        @(posedge clk);
        #1;
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            b = mk_bus(($urandom_range(0, 2) == 0) ? 4'(0) : 4'($urandom),
                       2'($urandom), 5'($urandom), $urandom, $urandom);
            b[69] = 1'($urandom);
            step(($urandom_range(0, 3) != 0), b, 10'($urandom), $urandom,
                 ($urandom_range(0, 9) < 7));
        end
        repeat (3) idle(1'b1);
        chk("drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
